// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared constants and register-index type for the register file slice
//
// Purpose : default geometry of the architectural register file and the
//           register-index type used by code built at that geometry.
// Ports   : none (package).

package reg_file_sb_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int REG_AW        = $clog2(DEFAULT_NREGS);

    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write busy bits with registered population count
//
// Purpose : tracks which architectural registers have an issued but not yet
//           written-back result.
// Ports   : clk, reset (async, active-low)
//           issue_valid/issue_rd : mark issue_rd pending at the next edge
//           we/wa                : writeback clears the pending mark of wa
//           flush                : clear every pending mark
//           busy                 : one bit per register, bit 0 always 0
//           pend_cnt             : number of set busy bits

module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Flush beats everything; otherwise the issue set is applied after the
    // writeback clear so a same-register issue/writeback leaves the bit set
    // (the newer instruction still owes a write).
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we) begin
                busy_nxt[wa] = 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
                busy_nxt[issue_rd] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Count from the next-state vector so the registered count always
    // matches the registered bits.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2-read/1-write register file with optional forwarding and pending-write scoreboard
//
// Purpose : architectural register file (x0 hardwired to zero) plus a
//           scoreboard reporting read-after-write hazards on the two sources.
// Ports   : clk, reset (async, active-low)
//           rs1_addr/rd1_data, rs2_addr/rd2_data : combinational read ports
//           we/wa/wd                             : writeback port
//           issue_valid/issue_rd, flush          : scoreboard control
//           rs1_busy, rs2_busy, hazard, pend_cnt : scoreboard status

module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int               XLEN      = DEFAULT_XLEN,
    parameter int               NREGS     = DEFAULT_NREGS,
    parameter int               BYPASS    = 1,
    parameter logic [XLEN-1:0]  RESET_VAL = '0,
    localparam int              AW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rd1_data,
    output logic [XLEN-1:0] rd2_data,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            hazard,
    output logic [AW:0]     pend_cnt
);

    localparam logic BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;
    logic             hit1;
    logic             hit2;

    assign wr_en = we && (wa != '0);

    // Entry 0 is held at zero and never written, so a plain index read of
    // x0 is already correct; the explicit zero mux below keeps that true
    // even if synthesis trims the constant entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Forwarding is purely combinational on the write port, so it also
    // works while reset is held (the write itself does not land then).
    assign hit1 = BYP_EN && wr_en && (wa == rs1_addr);
    assign hit2 = BYP_EN && wr_en && (wa == rs2_addr);

    always_comb begin
        rd1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        if (hit1) begin
            rd1_data = wd;
        end
    end

    always_comb begin
        rd2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        if (hit2) begin
            rd2_data = wd;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .we          (we),
        .wa          (wa),
        .flush       (flush),
        .busy        (busy),
        .pend_cnt    (pend_cnt)
    );

    // A source being written back this cycle is no longer a hazard when the
    // value is forwarded. busy[0] is never set, so wa==0 needs no guard.
    assign rs1_busy = busy[rs1_addr] && !(BYP_EN && we && (wa == rs1_addr));
    assign rs2_busy = busy[rs2_addr] && !(BYP_EN && we && (wa == rs2_addr));
    assign hazard   = rs1_busy || rs2_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (forwarding and non-forwarding builds)

module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    localparam int          XL  = 32;
    localparam int          NR  = 32;
    localparam logic [31:0] RV  = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    reg_idx_t    rs1_addr = '0, rs2_addr = '0, wa = '0, issue_rd = '0;
    logic        we = 1'b0, issue_valid = 1'b0, flush = 1'b0;
    logic [31:0] wd = '0;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_bz1, b_bz2, b_hz, n_bz1, n_bz2, n_hz;
    logic [5:0]  b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [NR];
    bit          pend [NR];

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(1), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(b_rd1), .rd2_data(b_rd2), .we(we), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .rs1_busy(b_bz1), .rs2_busy(b_bz2), .hazard(b_hz), .pend_cnt(b_cnt)
    );

    reg_file_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(0), .RESET_VAL(RV)) dut_nb (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd1_data(n_rd1), .rd2_data(n_rd2), .we(we), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .rs1_busy(n_bz1), .rs2_busy(n_bz2), .hazard(n_hz), .pend_cnt(n_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mem[i]  = (i == 0) ? 32'h0 : RV;
            pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            if (we && wa != 0) mem[wa] = wd;
            if (flush) begin
                for (int i = 0; i < NR; i++) pend[i] = 1'b0;
            end else begin
                if (we) pend[wa] = 1'b0;
                if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input reg_idx_t a, input bit byp);
        if (byp && we && wa != 0 && wa == a) return wd;
        return (a == 0) ? 32'h0 : mem[a];
    endfunction

    function automatic bit exp_busy(input reg_idx_t a, input bit byp);
        return pend[a] && !(byp && we && wa == a);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += pend[i];
        return n;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".byp.rd1"}, b_rd1, exp_rd(rs1_addr, 1));
        chk({tag, ".byp.rd2"}, b_rd2, exp_rd(rs2_addr, 1));
        chk({tag, ".byp.bz1"}, b_bz1, exp_busy(rs1_addr, 1));
        chk({tag, ".byp.bz2"}, b_bz2, exp_busy(rs2_addr, 1));
        chk({tag, ".byp.hz"},  b_hz,  exp_busy(rs1_addr, 1) || exp_busy(rs2_addr, 1));
        chk({tag, ".byp.cnt"}, b_cnt, exp_cnt());
        chk({tag, ".nb.rd1"},  n_rd1, exp_rd(rs1_addr, 0));
        chk({tag, ".nb.rd2"},  n_rd2, exp_rd(rs2_addr, 0));
        chk({tag, ".nb.bz1"},  n_bz1, exp_busy(rs1_addr, 0));
        chk({tag, ".nb.bz2"},  n_bz2, exp_busy(rs2_addr, 0));
        chk({tag, ".nb.hz"},   n_hz,  exp_busy(rs1_addr, 0) || exp_busy(rs2_addr, 0));
        chk({tag, ".nb.cnt"},  n_cnt, exp_cnt());
    endtask

    // Inputs are already set; check mid-cycle, then advance one edge.
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; issue_valid = 0; flush = 0; wa = '0; issue_rd = '0; wd = '0;
    endtask

    initial begin
        model_reset();
        // Held in reset: activity ignored, forwarding still visible.
        rs1_addr = 5'd5; rs2_addr = 5'd1;
        we = 1; wa = 5'd5; wd = 32'h1111_2222; issue_valid = 1; issue_rd = 5'd5;
        step("in_reset");
        step("in_reset2");
        idle();
        reset = 1'b1;

        for (int i = 1; i < NR; i++) begin
            rs1_addr = reg_idx_t'(i);
            rs2_addr = reg_idx_t'(NR - i);
            step("after_reset");
        end

        // x0 write ignored.
        we = 1; wa = 5'd0; wd = 32'hFFFF_FFFF; rs1_addr = 5'd0;
        step("x0_write");
        idle();
        step("x0_after");

        // Forwarding vs stored value.
        we = 1; wa = 5'd5; wd = 32'hDEAD_BEEF; rs2_addr = 5'd5;
        step("bypass");
        idle();
        step("bypass_next");

        // Scoreboard basics.
        issue_valid = 1; issue_rd = 5'd7;
        step("issue7");
        idle(); rs1_addr = 5'd7;
        step("busy7");
        issue_valid = 1; issue_rd = 5'd7; we = 1; wa = 5'd7; wd = 32'h0000_0777;
        step("issue_wb7");
        idle();
        step("still7");
        we = 1; wa = 5'd7; wd = 32'h0000_0778;
        step("wb7");
        idle();
        step("clear7");

        // Multiple pending, re-issue, flush beats issue.
        for (int r = 3; r <= 5; r++) begin
            issue_valid = 1; issue_rd = reg_idx_t'(r);
            step("issue345");
        end
        issue_valid = 1; issue_rd = 5'd4;
        step("reissue4");
        idle(); rs1_addr = 5'd3; rs2_addr = 5'd5;
        step("pend3");
        flush = 1; issue_valid = 1; issue_rd = 5'd6; we = 1; wa = 5'd4; wd = 32'h4444_0004;
        step("flush");
        idle();
        step("post_flush_a");
        rs1_addr = 5'd4; rs2_addr = 5'd6;
        step("post_flush_b");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            we          = ($urandom_range(0, 2) != 0);
            wa          = reg_idx_t'($urandom_range(0, NR - 1));
            wd          = $urandom;
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_rd    = reg_idx_t'($urandom_range(0, NR - 1));
            flush       = ($urandom_range(0, 19) == 0);
            rs1_addr    = ($urandom_range(0, 3) == 0) ? wa : reg_idx_t'($urandom_range(0, NR - 1));
            rs2_addr    = ($urandom_range(0, 3) == 0) ? issue_rd : reg_idx_t'($urandom_range(0, NR - 1));
            step("random");
        end

        // Asynchronous reset between edges.
        idle();
        issue_valid = 1; issue_rd = 5'd9;
        step("issue9");
        idle(); rs1_addr = 5'd9; rs2_addr = 5'd5;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        step("async_hold");
        reset = 1'b1;
        we = 1; wa = 5'd9; wd = 32'h0909_0909; issue_valid = 1; issue_rd = 5'd10; rs2_addr = 5'd10;
        step("post_release");
        idle();
        step("post_release2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register, in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; SHALL be a power of two and at least 2.
REQ-003 Parameter BYPASS, default 1: 1 = write-to-read forwarding in the same cycle; 0 = reads return stored contents only.
REQ-004 Parameter RESET_VAL, default 0: value loaded into registers 1..NREGS-1 at reset.
REQ-005 Derived constant AW = clog2(NREGS): register address width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset; one clock, asynchronous active-low reset, no other clock or reset.
REQ-008 rs1_addr  in  AW  read port 1 register address.
REQ-009 rs2_addr  in  AW  read port 2 register address.
REQ-010 rd1_data  out  XLEN  read port 1 data.
REQ-011 rd2_data  out  XLEN  read port 2 data.
REQ-012 we  in  1  writeback valid.
REQ-013 wa  in  AW  writeback destination register.
REQ-014 wd  in  XLEN  writeback data.
REQ-015 issue_valid  in  1  an instruction writing issue_rd has issued; mark it pending.
REQ-016 issue_rd  in  AW  destination of the issued instruction.
REQ-017 flush  in  1  pipeline flush; clear all pending marks.
REQ-018 rs1_busy, rs2_busy  out  1 each  source register has a pending write.
REQ-019 hazard  out  1  rs1_busy OR rs2_busy.
REQ-020 pend_cnt  out  AW+1  number of registers currently marked pending.

Function
REQ-021 Register 0 SHALL always read 0; writes to it SHALL be ignored; it SHALL never be marked pending.
REQ-022 Write: at a rising edge with we=1 and wa!=0, regs[wa] <= wd; single write port.
REQ-023 Reads SHALL be combinational (zero latency) from the address inputs.
REQ-024 With BYPASS=1, we=1, wa!=0 and wa==rsN_addr: rdN_data = wd in that same cycle; with BYPASS=0: rdN_data = stored value, and the new value is visible from the next cycle.
REQ-025 Scoreboard: one busy bit per register; issue_valid=1 with issue_rd!=0 sets busy[issue_rd] at the next edge.
REQ-026 Writeback: we=1 clears busy[wa] at the edge.
REQ-027 Same edge, issue_rd==wa: set wins, so the bit stays 1 because a newer write is pending.
REQ-028 flush=1: all busy bits are cleared at the edge; flush takes priority over a simultaneous issue; register contents are unaffected; a simultaneous write still lands.
REQ-029 rsN_busy = busy[rsN_addr], except with BYPASS=1 and we=1 and wa==rsN_addr: reported 0 that cycle.
REQ-030 Issuing to a register already pending SHALL keep it busy with no error; pend_cnt is unchanged.
REQ-031 pend_cnt SHALL equal the population count of the busy bits, registered, and consistent with the busy bits after every edge.

Reset
REQ-032 reset low SHALL immediately force registers 1..NREGS-1 to RESET_VAL, all busy bits to 0 and pend_cnt to 0, independent of clk.
REQ-033 While reset is low, writes, issues and flushes SHALL be ignored; rd*_data reflect the reset contents, except that the BYPASS path still forwards wd.
REQ-034 Reset asserted mid-operation SHALL discard all pending state; the first edge after release behaves normally.

Structure
REQ-035 A shared package SHALL hold the default XLEN/NREGS constants and the register-index type; reg_file_sb imports it.
REQ-036 The busy-bit array with pend_cnt SHALL be the sub-module reg_scoreboard; the storage array SHALL stay in reg_file_sb.

Verification
REQ-037 Reset low, then high; read x1..x31 -> each reads RESET_VAL, busy=0, pend_cnt=0.
REQ-038 we=1, wa=0, wd=FFFFFFFF; rs1_addr=0 -> rd1_data=0 in that cycle and afterwards.
REQ-039 BYPASS=1: we=1, wa=5, wd=DEADBEEF, rs2_addr=5 in the same cycle -> rd2_data=DEADBEEF that cycle; with BYPASS=0, the old value that cycle and DEADBEEF the next cycle.
REQ-040 Issue rd=7; next cycle rs1_addr=7 -> rs1_busy=1, hazard=1, pend_cnt=1; same edge issue rd=7 and we wa=7 -> still busy; writeback only -> busy=0, pend_cnt=0.
REQ-041 Issue x3, x4, x5 -> pend_cnt=3; flush with simultaneous issue x6 -> all busy=0, pend_cnt=0, data in x3..x6 unchanged.
REQ-042 Issue x9, then drop reset asynchronously between edges -> busy[9]=0 and regs=RESET_VAL before the next clk edge.
